// File: rtl/angstrom_pkg.sv
// angstrom_pkg: CPU control-vector bit indices and the io_bridge input-side state
package angstrom_pkg;
  localparam int CTRL_ALU = 0;
  localparam int CTRL_OUT = 1;
  localparam int CTRL_INP = 2;
  localparam int CTRL_MW  = 3;
  localparam int CTRL_MR  = 4;
  localparam int CTRL_JMP = 5;
  localparam int CTRL_IMM = 6;
  typedef enum logic {IN_EMPTY, IN_HELD} in_state_e;
endpackage

// File: rtl/io_bridge_if.sv
// io_bridge_if: CPU, external byte handshake and status signals; drop_cnt_o exists only with IO_BRIDGE_STATS_EN
interface io_bridge_if;
  logic [7:0] cpu_aob_i;
  logic [6:0] cpu_ctrl_i;
  logic [7:0] cpu_aib_o;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       clr_i;
  logic       ovf_o;
  logic       udf_o;
`ifdef IO_BRIDGE_STATS_EN
  logic [7:0] drop_cnt_o;
`endif
  modport slave (
    input  cpu_aob_i, cpu_ctrl_i, in_data_i, in_valid_i, out_ready_i, clr_i,
    output cpu_aib_o, in_ready_o, out_data_o, out_valid_o, ovf_o, udf_o
`ifdef IO_BRIDGE_STATS_EN
    , output drop_cnt_o
`endif
  );
  modport master (
    output cpu_aob_i, cpu_ctrl_i, in_data_i, in_valid_i, out_ready_i, clr_i,
    input  cpu_aib_o, in_ready_o, out_data_o, out_valid_o, ovf_o, udf_o
`ifdef IO_BRIDGE_STATS_EN
    , input drop_cnt_o
`endif
  );
endinterface

// File: rtl/io_bridge_fifo_sync.sv
// fifo_sync: single-clock FIFO; a push into a full FIFO is accepted only when a pop happens the same edge
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/io_bridge.sv
// io_bridge: CPU OUT/INP strobes to external byte streams via output FIFO and input holding register
// Optional drop counter enabled by IO_BRIDGE_STATS_EN
module io_bridge
  import angstrom_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input logic        clk_i,
  input logic        rst_ni,
  io_bridge_if.slave bus
);
  in_state_e state, state_nx;
  logic [7:0] hold;
  logic out_push, out_pop, out_full, out_empty, drop, inp, ovf, udf;
  assign out_push = bus.cpu_ctrl_i[CTRL_OUT];
  assign inp = bus.cpu_ctrl_i[CTRL_INP];
  assign out_pop = !out_empty && bus.out_ready_i;
  assign drop = out_push && out_full && !out_pop;
  fifo_sync #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (out_push),
    .pop   (out_pop),
    .din   (bus.cpu_aob_i),
    .dout  (bus.out_data_o),
    .full  (out_full),
    .empty (out_empty)
  );
  assign bus.out_valid_o = !out_empty;
  always_comb begin
    state_nx = state;
    state_nx = state == IN_EMPTY ? (bus.in_valid_i ? IN_HELD : IN_EMPTY) : (inp ? IN_EMPTY : IN_HELD);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IN_EMPTY;
      hold  <= 8'h00;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IN_EMPTY && bus.in_valid_i) hold <= bus.in_data_i;
      ovf <= drop | (ovf & ~bus.clr_i);
      udf <= (inp && state == IN_EMPTY) | (udf & ~bus.clr_i);
    end
  end
  // ready is forced low during reset so no byte is accepted before the bridge is live
  assign bus.in_ready_o = rst_ni && state == IN_EMPTY;
  assign bus.cpu_aib_o = state == IN_HELD ? hold : 8'h00;
  assign bus.ovf_o = ovf;
  assign bus.udf_o = udf;
`ifdef IO_BRIDGE_STATS_EN
  logic [7:0] drop_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) drop_cnt <= 8'h00;
    else if (drop) drop_cnt <= drop_cnt + {7'b0, drop_cnt != 8'hFF};
    else if (bus.clr_i) drop_cnt <= 8'h00;
  end
  assign bus.drop_cnt_o = drop_cnt;
`endif
endmodule
